// File: rtl/priority_encoder_rr_if.sv
// Request/grant bundle for priority_encoder_rr.
// The master drives requests and acceptance; the slave (the encoder) returns the registered grant.
interface priority_encoder_rr_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic         E;
  logic [N-1:0] I;
  logic         mode;
  logic         ready;
  logic [W-1:0] Y;
  logic [N-1:0] G;
  logic         valid;
  logic         multi;

  modport master (
    output E, I, mode, ready,
    input  Y, G, valid, multi
  );

  modport slave (
    input  E, I, mode, ready,
    output Y, G, valid, multi
  );
endinterface

// File: rtl/priority_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with a fixed-priority mode and a round-robin mode,
// presenting its grant through a one-deep valid/ready output stage.
module priority_encoder_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input logic                 clk,
  input logic                 rst,
  priority_encoder_rr_if.slave bus
);

  logic [W-1:0] y_q;
  logic [N-1:0] g_q;
  logic         valid_q;
  logic         multi_q;
  logic [W-1:0] ptr_q;

  logic [W-1:0] fixed_win;
  logic [W-1:0] rr_win;
  logic [W-1:0] winner;
  logic         cap;
  logic         many;

  // Highest set index wins: later loop iterations overwrite earlier ones.
  always_comb begin
    fixed_win = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.I[i]) fixed_win = W'(i);
    end
  end

  // Scan from the far end back toward ptr+1 so the nearest set bit after ptr is kept;
  // W-bit addition wraps modulo N because N is a power of two.
  always_comb begin
    rr_win = '0;
    for (int k = N; k >= 1; k--) begin
      if (bus.I[ptr_q + W'(k)]) rr_win = ptr_q + W'(k);
    end
  end

  assign winner = bus.mode ? rr_win : fixed_win;
  assign cap    = bus.E && (bus.I != '0) && (!valid_q || bus.ready);
  assign many   = (bus.I & (bus.I - N'(1))) != '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      g_q     <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      ptr_q   <= W'(N - 1);
    end else if (cap) begin
      y_q     <= winner;
      g_q     <= N'(1) << winner;
      valid_q <= 1'b1;
      multi_q <= many;
      if (bus.mode) ptr_q <= winner;
    end else if (bus.ready) begin
      // Y and multi keep their last value once the grant drains.
      valid_q <= 1'b0;
      g_q     <= '0;
    end
  end

  assign bus.Y     = y_q;
  assign bus.G     = g_q;
  assign bus.valid = valid_q;
  assign bus.multi = multi_q;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Self-checking bench for priority_encoder_rr: directed scenarios followed by random traffic,
// all compared against a behavioural model of the grant rules.
module tb_priority_encoder_rr;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic clk;
  logic rst;

  priority_encoder_rr_if #(.N(N), .W(W)) bus ();

  priority_encoder_rr #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  int           m_ptr;
  bit           m_valid;
  int           m_y;
  logic [N-1:0] m_g;
  bit           m_multi;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fixedPick(input logic [N-1:0] req);
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) return i;
    end
    return 0;
  endfunction

  function automatic int rrPick(input logic [N-1:0] req, input int ptr);
    for (int step = 1; step <= N; step++) begin
      if (req[(ptr + step) % N]) return (ptr + step) % N;
    end
    return 0;
  endfunction

  task automatic modelReset();
    m_ptr   = N - 1;
    m_valid = 0;
    m_y     = 0;
    m_g     = '0;
    m_multi = 0;
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".valid"}, 32'(bus.valid), 32'(m_valid));
    checkOutput({tag, ".Y"},     32'(bus.Y),     32'(m_y));
    checkOutput({tag, ".G"},     32'(bus.G),     32'(m_g));
    checkOutput({tag, ".multi"}, 32'(bus.multi), 32'(m_multi));
  endtask

  task automatic applyStimulus(input bit e, input logic [N-1:0] req, input bit m, input bit r,
                               input string tag);
    bit cap;
    int w;
    @(negedge clk);
    bus.E     = e;
    bus.I     = req;
    bus.mode  = m;
    bus.ready = r;
    @(posedge clk);
    cap = e && (req != 0) && (!m_valid || r);
    if (cap) begin
      w       = m ? rrPick(req, m_ptr) : fixedPick(req);
      m_y     = w;
      m_g     = N'(1) << w;
      m_valid = 1;
      m_multi = $countones(req) > 1;
      if (m) m_ptr = w;
    end else if (m_valid && r) begin
      m_valid = 0;
      m_g     = '0;
    end
    #1;
    compareAll(tag);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    modelReset();
    compareAll(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    bus.E     = 1'b0;
    bus.I     = '0;
    bus.mode  = 1'b0;
    bus.ready = 1'b0;
    modelReset();
    #12;
    compareAll("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < N; i++) applyStimulus(1, N'(1) << i, 0, 1, "onehot");

    applyStimulus(1, 8'b10010110, 0, 1, "fixed_multi");
    applyStimulus(0, 8'b10010110, 0, 1, "disabled_drain");
    applyStimulus(0, 8'b10010110, 0, 1, "disabled_idle");

    doReset("reset2");
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'b10010110, 1, 1, "rr_rotate");

    applyStimulus(1, 8'b00001000, 0, 1, "bp_load");
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'b11110000, 0, 0, "bp_hold");
    applyStimulus(1, 8'b11110000, 0, 1, "bp_release");

    doReset("reset3");
    applyStimulus(1, 8'b01000000, 1, 1, "rr_to6");
    applyStimulus(1, 8'b01000000, 1, 1, "rr_self");
    applyStimulus(1, 8'b00000000, 1, 1, "rr_empty");

    applyStimulus(1, 8'b00100000, 0, 1, "pre_midreset");
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    compareAll("midreset");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 8'b11111111, 1, 1, "post_reset_rr");

    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] req;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0)      req = '0;
      else if (sel == 1) req = N'(1) << $urandom_range(0, N - 1);
      else               req = N'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, req, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) != 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
